// File: rtl/binary2bcd_seq_if.sv
// Start/done bus of the sequential binary-to-BCD converter.
// Handshake: start is sampled only while the converter is idle (dbg_state==0); busy rises on the
// accepting edge, done is a one-cycle pulse when bcd/ascii/overflow update, and those hold until the next done.
interface binary2bcd_seq_if #(
    parameter int N       = 16,
    parameter int NDIGITS = 5
);
    logic                   start;
    logic [N-1:0]           number;
    logic                   busy;
    logic                   done;
    logic [4*NDIGITS-1:0]   bcd;
    logic [8*NDIGITS-1:0]   ascii;
    logic                   overflow;
    logic [1:0]             dbg_state;

    modport master (
        output start, number,
        input  busy, done, bcd, ascii, overflow, dbg_state
    );

    modport slave (
        input  start, number,
        output busy, done, bcd, ascii, overflow, dbg_state
    );
endinterface

// File: rtl/binary2bcd_seq.sv
// Multi-cycle double-dabble binary-to-BCD converter with ASCII rendering, one shift per input bit.
// Define BCD_ASCII_BLANK_EN to render leading zero digits as '_' (digit 0 is never blanked).
module binary2bcd_seq #(
    parameter int N       = 16,
    parameter int NDIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    binary2bcd_seq_if.slave       bus
);
    localparam int BW = 4 * NDIGITS;
    localparam int AW = 8 * NDIGITS;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [N-1:0]    shreg;
    logic [BW-1:0]   scratch;
    logic [BW-1:0]   adj;
    logic            ovf_s;
    logic [CW-1:0]   cnt;
    logic [BW-1:0]   bcd_q;
    logic [AW-1:0]   ascii_q;
    logic [AW-1:0]   ascii_r;
    logic            ovf_q;
    logic            done_q;
    logic            busy_q;
    logic [3:0]      ad;
    logic [3:0]      rd;
`ifdef BCD_ASCII_BLANK_EN
    logic            lead;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Add-3 correction on every digit before the shift.
    always_comb begin
        adj = '0;
        ad  = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            ad = scratch[4*i +: 4];
            adj[4*i +: 4] = (ad >= 4'd5) ? ad + 4'd3 : ad;
        end
    end

    always_comb begin
        ascii_r = '0;
        rd      = '0;
`ifdef BCD_ASCII_BLANK_EN
        lead    = 1'b1;
`endif
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            rd = scratch[4*i +: 4];
`ifdef BCD_ASCII_BLANK_EN
            if (lead && (rd == 4'd0) && (i != 0)) begin
                ascii_r[8*i +: 8] = 8'h5F;
            end else begin
                lead = 1'b0;
                ascii_r[8*i +: 8] = {4'h3, rd};
            end
`else
            ascii_r[8*i +: 8] = {4'h3, rd};
`endif
        end
    end

    // The carry leaving the top digit is worth exactly 10^NDIGITS, so dropping it leaves the value mod 10^NDIGITS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg   <= '0;
            scratch <= '0;
            ovf_s   <= 1'b0;
            cnt     <= '0;
            bcd_q   <= '0;
            ascii_q <= {NDIGITS{8'h30}};
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg   <= bus.number;
                        scratch <= '0;
                        ovf_s   <= 1'b0;
                        cnt     <= CW'(N);
                    end
                end
                SHIFT: begin
                    shreg   <= shreg << 1;
                    scratch <= {adj[BW-2:0], shreg[N-1]};
                    ovf_s   <= ovf_s | adj[BW-1];
                    cnt     <= cnt - CW'(1);
                end
                DONE: begin
                    bcd_q   <= scratch;
                    ascii_q <= ascii_r;
                    ovf_q   <= ovf_s;
                end
                default: ;
            endcase
            done_q <= (state == DONE);
            // busy covers the done cycle and only drops if no new start is taken right after it.
            busy_q <= (state_nxt != IDLE) || (state == DONE);
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.bcd       = bcd_q;
    assign bus.ascii     = ascii_q;
    assign bus.overflow  = ovf_q;
    assign bus.dbg_state = state;
endmodule

// File: tb/tb_binary2bcd_seq.sv
// Directed bench for binary2bcd_seq: a default 16-bit/5-digit instance and a 10-bit/3-digit instance.
module tb_binary2bcd_seq;
`ifdef BCD_ASCII_BLANK_EN
    localparam bit BLANK = 1'b1;
`else
    localparam bit BLANK = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    binary2bcd_seq_if #(.N(16), .NDIGITS(5)) bus16 ();
    binary2bcd_seq_if #(.N(10), .NDIGITS(3)) bus10 ();

    binary2bcd_seq #(.N(16), .NDIGITS(5)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    binary2bcd_seq #(.N(10), .NDIGITS(3)) u_dut10 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus10)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic convert16(input string tag, input logic [15:0] v, input logic [19:0] eb,
                             input logic [39:0] ea_plain, input logic [39:0] ea_blank, input logic eo);
        int cyc;
        bus16.number = v;
        bus16.start  = 1'b1;
        tick();
        bus16.start  = 1'b0;
        bus16.number = 16'($urandom_range(0, 65535));
        check({tag, "_busy_after_accept"}, 64'(bus16.busy), 64'd1);
        cyc = 0;
        while (!bus16.done && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd17);
        check({tag, "_bcd"}, 64'(bus16.bcd), 64'(eb));
        check({tag, "_ascii"}, 64'(bus16.ascii), 64'(BLANK ? ea_blank : ea_plain));
        check({tag, "_overflow"}, 64'(bus16.overflow), 64'(eo));
        tick();
        check({tag, "_done_pulse"}, 64'(bus16.done), 64'd0);
        check({tag, "_busy_drop"}, 64'(bus16.busy), 64'd0);
        check({tag, "_bcd_hold"}, 64'(bus16.bcd), 64'(eb));
    endtask

    task automatic convert10(input string tag, input logic [9:0] v, input logic [11:0] eb,
                             input logic [23:0] ea_plain, input logic [23:0] ea_blank, input logic eo);
        int cyc;
        bus10.number = v;
        bus10.start  = 1'b1;
        tick();
        bus10.start  = 1'b0;
        cyc = 0;
        while (!bus10.done && cyc < 40) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, 64'(cyc), 64'd11);
        check({tag, "_bcd"}, 64'(bus10.bcd), 64'(eb));
        check({tag, "_ascii"}, 64'(bus10.ascii), 64'(BLANK ? ea_blank : ea_plain));
        check({tag, "_overflow"}, 64'(bus10.overflow), 64'(eo));
        tick();
        check({tag, "_done_pulse"}, 64'(bus10.done), 64'd0);
    endtask

    initial begin
        int  cyc;
        bit  busy_ok;
        n_checks     = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        bus16.start  = 1'b0;
        bus16.number = '0;
        bus10.start  = 1'b0;
        bus10.number = '0;
        tick();
        tick();
        check("rst_busy", 64'(bus16.busy), 64'd0);
        check("rst_done", 64'(bus16.done), 64'd0);
        check("rst_bcd", 64'(bus16.bcd), 64'd0);
        check("rst_ascii", 64'(bus16.ascii), 64'h30_3030_3030);
        check("rst_overflow", 64'(bus16.overflow), 64'd0);
        check("rst_state", 64'(bus16.dbg_state), 64'd0);
        check("rst_ascii10", 64'(bus10.ascii), 64'h30_3030);
        rst_n = 1'b1;
        tick();

        convert16("v1234", 16'd1234, 20'h01234, 40'h30_3132_3334, 40'h5F_3132_3334, 1'b0);
        convert16("v0", 16'd0, 20'h00000, 40'h30_3030_3030, 40'h5F_5F5F_5F30, 1'b0);
        convert16("v65535", 16'd65535, 20'h65535, 40'h36_3535_3335, 40'h36_3535_3335, 1'b0);

        convert10("n10_1023", 10'd1023, 12'h023, 24'h30_3233, 24'h5F_3233, 1'b1);
        convert10("n10_999", 10'd999, 12'h999, 24'h39_3939, 24'h39_3939, 1'b0);
        convert10("n10_1000", 10'd1000, 12'h000, 24'h30_3030, 24'h5F_5F30, 1'b1);

        // A second start mid-conversion must be ignored.
        bus16.number = 16'd500;
        bus16.start  = 1'b1;
        tick();
        bus16.start  = 1'b0;
        busy_ok = 1'b1;
        cyc = 0;
        while (!bus16.done && cyc < 40) begin
            if (cyc == 5) begin
                bus16.number = 16'd9;
                bus16.start  = 1'b1;
            end else begin
                bus16.start  = 1'b0;
            end
            if (!bus16.busy) busy_ok = 1'b0;
            tick();
            cyc++;
        end
        bus16.start = 1'b0;
        check("restart_busy_continuous", 64'(busy_ok), 64'd1);
        check("restart_latency", 64'(cyc), 64'd17);
        check("restart_bcd", 64'(bus16.bcd), 64'h00500);
        check("restart_ascii", 64'(bus16.ascii), BLANK ? 64'h5F_5F35_3030 : 64'h30_3035_3030);
        tick();
        check("restart_idle_after", 64'(bus16.busy), 64'd0);

        // Asynchronous reset in the middle of a conversion.
        bus16.number = 16'd777;
        bus16.start  = 1'b1;
        tick();
        bus16.start  = 1'b0;
        repeat (8) tick();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 64'(bus16.busy), 64'd0);
        check("midrst_done", 64'(bus16.done), 64'd0);
        check("midrst_bcd", 64'(bus16.bcd), 64'd0);
        check("midrst_ascii", 64'(bus16.ascii), 64'h30_3030_3030);
        check("midrst_state", 64'(bus16.dbg_state), 64'd0);
        tick();
        rst_n = 1'b1;
        cyc = 0;
        busy_ok = 1'b1;
        repeat (20) begin
            tick();
            if (bus16.done) busy_ok = 1'b0;
        end
        check("midrst_no_done", 64'(busy_ok), 64'd1);
        convert16("v42", 16'd42, 20'h00042, 40'h30_3030_3432, 40'h5F_5F5F_3432, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
